// File: rtl/lift_pkg.sv
// Shared types and constants for the lift scheduler: FSM states, direction codes, default sizing.
package lift_pkg;
    localparam int FLOOR_W        = 4;
    localparam int N_FLOORS_DEF   = 9;
    localparam int DOOR_TICKS_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_DOOR
    } state_t;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;
endpackage

// File: rtl/lift_req_search.sv
// Combinational scan of the pending-call bitmap relative to the cabin position.
module lift_req_search
    import lift_pkg::*;
#(
    parameter int N_FLOORS = N_FLOORS_DEF
) (
    input  logic [N_FLOORS-1:0] i_pending,
    input  logic [FLOOR_W-1:0]  i_cur_floor,
    output logic                o_any_above,
    output logic                o_any_below
);
    always_comb begin
        o_any_above = 1'b0;
        o_any_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i_pending[i]) begin
                if (i > int'(i_cur_floor)) o_any_above = 1'b1;
                if (i < int'(i_cur_floor)) o_any_below = 1'b1;
            end
        end
    end
endmodule

// File: rtl/lift_scheduler.sv
// Single-cabin lift controller: collects floor calls, sweeps in the last direction
// while calls remain ahead, and dwells with the door open at each called floor.
module lift_scheduler
    import lift_pkg::*;
#(
    parameter int N_FLOORS   = N_FLOORS_DEF,
    parameter int DOOR_TICKS = DOOR_TICKS_DEF
) (
    input  logic                CLOCK_50,
    input  logic                iRST_N,
    input  logic                tick,
    input  logic                req_valid,
    input  logic [FLOOR_W-1:0]  req_floor,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic [1:0]          dir,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending,
    output logic                arrive
);
    localparam int DW = (DOOR_TICKS < 1) ? 1 : $clog2(DOOR_TICKS + 1);
    localparam logic [N_FLOORS-1:0] ONE = {{(N_FLOORS-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [FLOOR_W-1:0]    r_floor;
    logic [N_FLOORS-1:0]   r_pending;
    logic [DW-1:0]         r_dwell;
    logic                  r_last_up;
    logic [1:0]            r_dir;
    logic                  r_door;
    logic                  r_arrive;

    logic                  w_call_ok, w_call_here, w_moving, w_at_end, w_step, w_hit;
    logic                  w_any_above, w_any_below;
    logic [FLOOR_W-1:0]    w_new_floor;
    logic [N_FLOORS-1:0]   w_req_oh, w_new_oh, w_pend_nxt;

    lift_req_search #(.N_FLOORS(N_FLOORS)) u_search (
        .i_pending   (r_pending),
        .i_cur_floor (r_floor),
        .o_any_above (w_any_above),
        .o_any_below (w_any_below)
    );

    assign w_call_ok   = req_valid && (int'(req_floor) < N_FLOORS);
    assign w_call_here = w_call_ok && (req_floor == r_floor);
    assign w_moving    = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DOWN);
    assign w_at_end    = (r_state == ST_MOVE_UP)   ? (r_floor == FLOOR_W'(N_FLOORS - 1))
                       : (r_state == ST_MOVE_DOWN) ? (r_floor == '0) : 1'b0;
    assign w_step      = tick && w_moving && !w_at_end;
    assign w_new_floor = (r_state == ST_MOVE_UP) ? r_floor + 1'b1 : r_floor - 1'b1;
    assign w_req_oh    = ONE << req_floor;
    assign w_new_oh    = ONE << w_new_floor;
    assign w_hit       = w_step && |(r_pending & w_new_oh);

    // A call for the floor being arrived at is cleared with the arrival, so it only extends the dwell.
    always_comb begin
        w_pend_nxt = r_pending;
        if (w_call_ok && (!w_call_here || w_moving)) w_pend_nxt = w_pend_nxt | w_req_oh;
        if (w_hit) w_pend_nxt = w_pend_nxt & ~w_new_oh;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!iRST_N) begin
            r_state   <= ST_IDLE;
            r_floor   <= '0;
            r_pending <= '0;
            r_dwell   <= '0;
            r_last_up <= 1'b1;
            r_dir     <= DIR_STOP;
            r_door    <= 1'b0;
            r_arrive  <= 1'b0;
        end else begin
            r_arrive  <= 1'b0;
            r_pending <= w_pend_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_call_here) begin
                        r_state  <= ST_DOOR;
                        r_dwell  <= DW'(DOOR_TICKS);
                        r_door   <= 1'b1;
                        r_arrive <= 1'b1;
                    end else if ((r_last_up && w_any_above) || (!w_any_below && w_any_above)) begin
                        r_state   <= ST_MOVE_UP;
                        r_dir     <= DIR_UP;
                        r_last_up <= 1'b1;
                    end else if (w_any_below) begin
                        r_state   <= ST_MOVE_DOWN;
                        r_dir     <= DIR_DOWN;
                        r_last_up <= 1'b0;
                    end
                end
                ST_MOVE_UP, ST_MOVE_DOWN: begin
                    if (tick && w_at_end) begin
                        r_state <= ST_IDLE;
                        r_dir   <= DIR_STOP;
                    end else if (w_step) begin
                        r_floor <= w_new_floor;
                        if (w_hit) begin
                            r_state  <= ST_DOOR;
                            r_dir    <= DIR_STOP;
                            r_dwell  <= DW'(DOOR_TICKS);
                            r_door   <= 1'b1;
                            r_arrive <= 1'b1;
                        end
                    end
                end
                ST_DOOR: begin
                    if (w_call_here) begin
                        r_dwell <= DW'(DOOR_TICKS);
                    end else if (tick) begin
                        if (r_dwell <= DW'(1)) begin
                            r_dwell <= '0;
                            r_state <= ST_IDLE;
                            r_door  <= 1'b0;
                        end else begin
                            r_dwell <= r_dwell - 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cur_floor = r_floor;
    assign dir       = r_dir;
    assign door_open = r_door;
    assign pending   = r_pending;
    assign arrive    = r_arrive;
endmodule

// File: tb/tb_lift_scheduler.sv
// Self-checking bench: expected arrival floors queued with each call, popped on every arrive pulse.
module tb_lift_scheduler;
    import lift_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, tick, req_valid;
    logic [3:0]  req_floor;
    logic [3:0]  cur_floor;
    logic [1:0]  dir;
    logic        door_open, arrive;
    logic [8:0]  pending;

    logic [31:0] q_arr[$];
    int          n_chk = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    lift_scheduler #(.N_FLOORS(9), .DOOR_TICKS(3)) dut (
        .CLOCK_50  (clk),
        .iRST_N    (rst_n),
        .tick      (tick),
        .req_valid (req_valid),
        .req_floor (req_floor),
        .cur_floor (cur_floor),
        .dir       (dir),
        .door_open (door_open),
        .pending   (pending),
        .arrive    (arrive)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && arrive === 1'b1) begin
            if (q_arr.size() == 0) chk("arr_extra", 32'd1, 32'd0);
            else                   chk("arr_floor", 32'(cur_floor), q_arr.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic call(input logic [3:0] f);
        req_valid = 1'b1;
        req_floor = f;
        cyc(1);
        req_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; req_valid = 1'b0; req_floor = '0;
        cyc(2);
        chk("rst_floor", 32'(cur_floor), 32'd0);
        chk("rst_pend",  32'(pending),   32'd0);
        chk("rst_dir",   32'(dir),       32'd0);
        chk("rst_door",  32'(door_open), 32'd0);
        chk("rst_arr",   32'(arrive),    32'd0);
        rst_n = 1'b1;
        cyc(1);

        // call 3 from floor 0
        call(4'd3);
        chk("s1_pend", 32'(pending), 32'h008);
        cyc(1);
        chk("s1_dir_up", 32'(dir), 32'd1);
        q_arr.push_back(32'd3);
        ticks(3);
        chk("s1_floor", 32'(cur_floor), 32'd3);
        chk("s1_door",  32'(door_open), 32'd1);
        chk("s1_pend0", 32'(pending),   32'd0);
        ticks(1); chk("s1_dw1", 32'(door_open), 32'd1);
        ticks(1); chk("s1_dw2", 32'(door_open), 32'd1);
        ticks(1); chk("s1_dw3", 32'(door_open), 32'd0);
        chk("s1_idle_dir", 32'(dir), 32'd0);

        // at 3 heading up: calls 5 and 1
        q_arr.push_back(32'd5);
        call(4'd5);
        q_arr.push_back(32'd1);
        call(4'd1);
        chk("s2_pend", 32'(pending), 32'h022);
        chk("s2_dir",  32'(dir),     32'd1);
        ticks(2);
        chk("s2_at5",   32'(cur_floor), 32'd5);
        chk("s2_pend1", 32'(pending),   32'h002);
        ticks(3);
        chk("s2_dir_dn", 32'(dir), 32'd2);
        ticks(4);
        chk("s2_at1", 32'(cur_floor), 32'd1);
        ticks(3);
        chk("s2_pend0", 32'(pending),   32'd0);
        chk("s2_door",  32'(door_open), 32'd0);
        chk("s2_dir0",  32'(dir),       32'd0);

        // same-floor call in IDLE and dwell reload
        q_arr.push_back(32'd2);
        call(4'd2);
        cyc(1);
        ticks(4);
        chk("s3_at2", 32'(cur_floor), 32'd2);
        chk("s3_closed", 32'(door_open), 32'd0);
        q_arr.push_back(32'd2);
        call(4'd2);
        chk("s3_door", 32'(door_open), 32'd1);
        chk("s3_pend", 32'(pending),   32'd0);
        ticks(1);
        tick = 1'b1; req_valid = 1'b1; req_floor = 4'd2;
        cyc(1);
        tick = 1'b0; req_valid = 1'b0;
        cyc(1);
        chk("s3_reload", 32'(door_open), 32'd1);
        chk("s3_pend_r", 32'(pending),   32'd0);
        ticks(2); chk("s3_more2", 32'(door_open), 32'd1);
        ticks(1); chk("s3_more3", 32'(door_open), 32'd0);

        // out-of-range calls
        call(4'd9);  chk("s4_pend9",  32'(pending), 32'd0);
        call(4'd15); chk("s4_pend15", 32'(pending), 32'd0);
        cyc(2);
        chk("s4_dir",   32'(dir),       32'd0);
        chk("s4_door",  32'(door_open), 32'd0);
        chk("s4_floor", 32'(cur_floor), 32'd2);

        // reset mid-travel
        call(4'd5);
        call(4'd7);
        call(4'd8);
        chk("s5_pend", 32'(pending), 32'h1A0);
        chk("s5_dir",  32'(dir),     32'd1);
        ticks(1);
        chk("s5_at3", 32'(cur_floor), 32'd3);
        rst_n = 1'b0;
        cyc(1);
        chk("s5_floor", 32'(cur_floor), 32'd0);
        chk("s5_pend0", 32'(pending),   32'd0);
        chk("s5_dir0",  32'(dir),       32'd0);
        chk("s5_door",  32'(door_open), 32'd0);
        chk("s5_arr",   32'(arrive),    32'd0);
        rst_n = 1'b1;
        ticks(4);
        chk("s5_stay", 32'(cur_floor), 32'd0);
        chk("s5_dir1", 32'(dir),       32'd0);

        chk("sb_left", 32'(q_arr.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/lift_scheduler.md
LIFT_SCHEDULER -- requirements
Module: lift_scheduler

Interface
REQ-001 Parameter N_FLOORS, default 9: number of served floors, numbered 0..N_FLOORS-1.
REQ-002 Parameter DOOR_TICKS, default 3: door-open dwell time, counted in ticks.
REQ-003 CLOCK_50  in  1: single clock; all logic on its rising edge.
REQ-004 iRST_N  in  1: reset, synchronous and active-low.
REQ-005 tick  in  1: one-cycle pulse; one floor of travel, or one dwell step, per pulse.
REQ-006 req_valid  in  1: floor call is present this cycle.
REQ-007 req_floor  in  4: floor being called; qualified by req_valid.
REQ-008 cur_floor  out  4: current cabin floor.
REQ-009 dir  out  2: 00 stopped, 01 up, 10 down.
REQ-010 door_open  out  1: door open, so the cabin is dwelling.
REQ-011 pending  out  N_FLOORS: registered bitmap of outstanding calls.
REQ-012 arrive  out  1: one-cycle pulse when the cabin stops at a called floor.

Function
REQ-013 The FSM SHALL have states IDLE, MOVE_UP, MOVE_DOWN and DOOR; dir SHALL read 00 in IDLE and DOOR.
REQ-014 A call with req_floor >= N_FLOORS SHALL be ignored with no state change.
REQ-015 A valid call != cur_floor SHALL set pending[req_floor] at the next edge; a repeat of an already-set bit SHALL have no further effect.
REQ-016 A valid call == cur_floor SHALL leave pending unchanged:
- in IDLE, the next state SHALL be DOOR with arrive pulsed;
- in DOOR, the dwell counter SHALL reload to DOOR_TICKS;
- in MOVE_*, the call SHALL set pending.
REQ-017 IDLE decision, one cycle after entry, using registered last_dir:
- if last_dir is up and any pending bit is above cur_floor, go to MOVE_UP;
- else if any pending bit is below, go to MOVE_DOWN;
- else if any pending bit is above, go to MOVE_UP;
- else stay in IDLE.
- last_dir SHALL reset to up.
REQ-018 In MOVE_UP, each tick SHALL increment cur_floor by 1; MOVE_DOWN SHALL decrement by 1; no other cycle changes cur_floor.
REQ-019 When the new floor's pending bit is set, on the same edge the FSM SHALL:
- clear that bit;
- go to DOOR;
- load the dwell counter with DOOR_TICKS;
- pulse arrive, visible in the cycle after the edge.
REQ-020 Otherwise the FSM SHALL continue in the same direction; it SHALL never move beyond floor 0 or N_FLOORS-1.
REQ-021 In DOOR, each tick SHALL decrement the dwell counter; the tick that reaches 0 SHALL move the FSM to IDLE; door_open SHALL be 1 only in DOOR.
REQ-022 A call and a tick in the same cycle SHALL both take effect; a call for the floor being arrived at on that edge SHALL be treated per REQ-016 (in DOOR).
REQ-023 Entering MOVE_UP SHALL set last_dir to up, and entering MOVE_DOWN SHALL set it to down.

Reset
REQ-024 While iRST_N=0 at an edge, the block SHALL set:
- state IDLE;
- cur_floor 0;
- pending 0;
- dwell counter 0;
- last_dir up;
- door_open 0, arrive 0, dir 00.
REQ-025 A reset mid-travel or mid-dwell SHALL discard all calls, with no arrive pulse generated.

Structure
REQ-026 Package lift_pkg SHALL hold:
- the state enum;
- the dir encodings;
- N_FLOORS and DOOR_TICKS defaults;
- the floor width constant (4).
REQ-027 Sub-module lift_req_search SHALL be combinational: it takes pending and cur_floor and returns any_above and any_below.

Verification
REQ-028 The bench SHALL cover these scenarios:
- Reset, then call floor 3 → MOVE_UP; after 3 ticks cur_floor=3, arrive pulses once, door_open=1 for 3 ticks, then IDLE.
- At floor 3 moving up, with calls 5 and 1 pending → stops at 5 first, then reverses to 1; pending=0 at end.
- Call floor 2 while IDLE at 2 → DOOR next cycle, pending stays 0; a second call for 2 at the 2nd dwell tick → door stays open 3 more ticks.
- Call floor 9 or 15 → ignored, pending=0, state IDLE.
- Reset asserted while moving between calls (pending=0x1A0) → next cycle cur_floor=0, pending=0, dir=00, door_open=0.
